lca_4: RTL and testbench

- 4-bit carry-lookahead adder with registered outputs.
- Computes S/CO = A_in + B_in + C_1 using flattened generate/propagate lookahead logic, with no ripple chain.
- Also exports registered group propagate/generate terms so several instances can be cascaded under a higher-level lookahead unit.
- Used as the basic adder slice in the arithmetic datapath.

---
 rtl/lca_4.sv | 60 ++++++
 tb/tb_lca_4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lca_4.sv
// rtl/lca_4.sv - 4-bit carry-lookahead adder slice with registered sum, carry-out and group P/G
// Carries are flattened sum-of-products so no carry ripples between bit positions.
module lca_4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A_in,
   input  logic [3:0] B_in,
   input  logic       C_1,
   output logic [3:0] S,
   output logic       CO,
   output logic       PG,
   output logic       GG
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;
   logic [3:0] s_d;
   logic       pg_d;
   logic       gg_d;

   logic [3:0] s_q;
   logic       co_q;
   logic       pg_q;
   logic       gg_q;

   always_comb begin
      p    = A_in ^ B_in;
      g    = A_in & B_in;
      c[0] = C_1;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      // Group generate excludes the carry-in so an upper lookahead unit can combine slices.
      gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg_d = p[3] & p[2] & p[1] & p[0];
      c[4] = gg_d | (pg_d & c[0]);
      s_d  = p ^ c[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q  <= 4'h0;
         co_q <= 1'b0;
         pg_q <= 1'b0;
         gg_q <= 1'b0;
      end else begin
         s_q  <= s_d;
         co_q <= c[4];
         pg_q <= pg_d;
         gg_q <= gg_d;
      end
   end

   assign S  = s_q;
   assign CO = co_q;
   assign PG = pg_q;
   assign GG = gg_q;

endmodule

// File: tb/tb_lca_4.sv
// tb/tb_lca_4.sv - self-checking bench for lca_4 using vector tables, sweeps and random stimulus
module tb_lca_4;

   logic       clk;
   logic       rst;
   logic [3:0] A_in;
   logic [3:0] B_in;
   logic       C_1;
   logic [3:0] S;
   logic       CO;
   logic       PG;
   logic       GG;

   int checks;
   int errors;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [3:0] s;
      logic       co;
      logic       pg;
      logic       gg;
   } vec_t;

   vec_t vecs[9];

   lca_4 dut (
      .clk (clk),
      .rst (rst),
      .A_in(A_in),
      .B_in(B_in),
      .C_1 (C_1),
      .S   (S),
      .CO  (CO),
      .PG  (PG),
      .GG  (GG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] es, input logic eco,
                        input logic epg, input logic egg);
      checks++;
      if (S !== es || CO !== eco || PG !== epg || GG !== egg) begin
         errors++;
         $display("FAIL %s: got S=%h CO=%b PG=%b GG=%b, expected S=%h CO=%b PG=%b GG=%b",
                  name, S, CO, PG, GG, es, eco, epg, egg);
      end
   endtask

   // Drive operands, let one rising edge capture them, then sample 1 time unit later.
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci);
      A_in = a;
      B_in = b;
      C_1  = ci;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer addition; group terms from their arithmetic meaning.
   task automatic model(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        output logic [3:0] es, output logic eco,
                        output logic epg, output logic egg);
      int sum;
      sum = int'(a) + int'(b) + int'(ci);
      es  = sum[3:0];
      eco = (sum >= 16);
      egg = ((int'(a) + int'(b)) >= 16);
      epg = ((int'(a) + int'(b)) == 15);
   endtask

   initial begin
      logic [3:0] es;
      logic       eco, epg, egg;
      logic [3:0] ra, rb;
      logic       rc;

      checks = 0;
      errors = 0;

      vecs[0] = '{a:4'h1, b:4'h1, ci:1'b1, s:4'h3, co:1'b0, pg:1'b0, gg:1'b0};
      vecs[1] = '{a:4'h2, b:4'h3, ci:1'b1, s:4'h6, co:1'b0, pg:1'b0, gg:1'b0};
      vecs[2] = '{a:4'h4, b:4'h5, ci:1'b0, s:4'h9, co:1'b0, pg:1'b0, gg:1'b0};
      vecs[3] = '{a:4'h7, b:4'h8, ci:1'b1, s:4'h0, co:1'b1, pg:1'b1, gg:1'b0};
      vecs[4] = '{a:4'hA, b:4'h5, ci:1'b0, s:4'hF, co:1'b0, pg:1'b1, gg:1'b0};
      vecs[5] = '{a:4'hA, b:4'h5, ci:1'b1, s:4'h0, co:1'b1, pg:1'b1, gg:1'b0};
      vecs[6] = '{a:4'h0, b:4'h0, ci:1'b0, s:4'h0, co:1'b0, pg:1'b0, gg:1'b0};
      vecs[7] = '{a:4'h0, b:4'h0, ci:1'b1, s:4'h1, co:1'b0, pg:1'b0, gg:1'b0};
      vecs[8] = '{a:4'h8, b:4'h8, ci:1'b0, s:4'h0, co:1'b1, pg:1'b0, gg:1'b1};

      // Reset held for two edges with all-ones operands.
      rst  = 1'b1;
      A_in = 4'hF;
      B_in = 4'hF;
      C_1  = 1'b1;
      step(4'hF, 4'hF, 1'b1);
      check("reset_edge1", 4'h0, 1'b0, 1'b0, 1'b0);
      step(4'hF, 4'hF, 1'b1);
      check("reset_edge2", 4'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(4'hF, 4'hF, 1'b1);
      check("after_release", 4'hF, 1'b1, 1'b0, 1'b1);

      // Directed vector table, one operation per cycle.
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].a, vecs[i].b, vecs[i].ci);
         check($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].pg, vecs[i].gg);
      end

      // Inputs changing between edges must not disturb held outputs.
      step(4'h7, 4'h8, 1'b1);
      A_in = 4'h0;
      B_in = 4'h0;
      C_1  = 1'b0;
      #3;
      check("hold_between_edges", 4'h0, 1'b1, 1'b1, 1'b0);

      // Reset asserted right after (7,8,1) was presented discards that result.
      A_in = 4'h7;
      B_in = 4'h8;
      C_1  = 1'b1;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      check("midstream_reset", 4'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(4'h7, 4'h8, 1'b1);
      check("first_after_midreset", 4'h0, 1'b1, 1'b1, 1'b0);

      // Exhaustive sweep, plus the carry invariant on every case.
      for (int k = 0; k < 512; k++) begin
         step(4'(k >> 5), 4'(k >> 1), k[0]);
         model(4'(k >> 5), 4'(k >> 1), k[0], es, eco, epg, egg);
         check($sformatf("sweep_a%0d_b%0d_c%0d", k >> 5, (k >> 1) & 15, k & 1),
               es, eco, epg, egg);
         checks++;
         if (CO !== (GG | (PG & k[0]))) begin
            errors++;
            $display("FAIL invariant_k%0d: CO=%b expected GG|(PG&C_1)=%b", k, CO,
                     GG | (PG & k[0]));
         end
      end

      // Random back-to-back stream.
      for (int n = 0; n < 300; n++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         step(ra, rb, rc);
         model(ra, rb, rc, es, eco, epg, egg);
         check($sformatf("rand%0d", n), es, eco, epg, egg);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
